// File: rtl/droop_ladder.sv
// Supply-droop brake ladder: picks a severity level from the brake requests,
// kicks the DCO code, then relaxes the divider back to nominal step by step.
module droop_ladder #(
  parameter int NLEVELS        = 4,
  parameter int W              = 16,
  parameter int DIV_PER_LEVEL  = 4,
  parameter int CODE_PER_LEVEL = 256,
  parameter int BRAKE_CYCLES   = 500,
  parameter int HOLD_CYCLES    = 32,
  parameter int DIV_STEP       = 1,
  parameter int CNT_W          = 16
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic [NLEVELS-1:0] brake,
  input  logic               enable,
  output logic [W-1:0]       delta_f,
  output logic [W-1:0]       delta_n,
  output logic [1:0]         state,
  output logic [3:0]         level,
  output logic               busy,
  output logic [CNT_W-1:0]   event_count
);

  localparam int BCW = (BRAKE_CYCLES < 1) ? 1 : $clog2(BRAKE_CYCLES + 1);
  localparam int HCW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam longint unsigned MAXF =
    longint'(NLEVELS) * longint'(CODE_PER_LEVEL);
  localparam longint unsigned MAXN =
    longint'(NLEVELS) * longint'(DIV_PER_LEVEL);

  if (NLEVELS < 1 || NLEVELS > 8) begin : g_bad_nlevels
    $error("droop_ladder: NLEVELS must be 1..8");
  end
  if ((MAXF >> W) != 0 || (MAXN >> W) != 0) begin : g_bad_width
    $error("droop_ladder: level products do not fit in W bits");
  end
  if (DIV_STEP < 1) begin : g_bad_step
    $error("droop_ladder: DIV_STEP must be >= 1");
  end

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BRAKE = 2'd1,
    S_RECOV = 2'd2,
    S_BAD   = 2'd3
  } state_e;

  state_e           state_q;
  logic [3:0]       level_q;
  logic [W-1:0]     div_q;
  logic [W-1:0]     kick_q;
  logic [BCW-1:0]   cnt_q;
  logic [HCW-1:0]   hold_q;
  logic [CNT_W-1:0] ev_q;

  logic [3:0]       req;
  logic [W-1:0]     req_div;
  logic [W-1:0]     req_kick;
  logic [CNT_W-1:0] ev_inc;

  // Highest asserted brake bit wins.
  always_comb begin
    req = '0;
    for (int k = 0; k < NLEVELS; k++) begin
      if (brake[k]) req = 4'(k + 1);
    end
  end

  assign req_div  = W'(req) * W'(DIV_PER_LEVEL);
  assign req_kick = W'(req) * W'(CODE_PER_LEVEL);
  assign ev_inc   = (ev_q == '1) ? ev_q : ev_q + 1'b1;

  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q <= S_OFF;
      level_q <= '0;
      div_q   <= '0;
      kick_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      ev_q    <= '0;
    end else begin
      kick_q <= '0;
      unique case (state_q)
        S_OFF: begin
          if (req != 4'd0 && enable) begin
            state_q <= S_BRAKE;
            level_q <= req;
            div_q   <= req_div;
            kick_q  <= req_kick;
            cnt_q   <= BCW'(BRAKE_CYCLES);
            ev_q    <= ev_inc;
          end
        end
        S_BRAKE: begin
          if (req > level_q) begin
            level_q <= req;
            div_q   <= req_div;
            kick_q  <= req_kick;
            cnt_q   <= BCW'(BRAKE_CYCLES);
            ev_q    <= ev_inc;
          end else if (req != 4'd0) begin
            cnt_q <= BCW'(BRAKE_CYCLES);
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_RECOV;
            hold_q  <= HCW'(HOLD_CYCLES);
          end
        end
        S_RECOV: begin
          if (req != 4'd0) begin
            state_q <= S_BRAKE;
            level_q <= req;
            cnt_q   <= BCW'(BRAKE_CYCLES);
            ev_q    <= ev_inc;
            // Re-brake never relaxes a divider that is still deeper.
            if (req_div > div_q) begin
              div_q  <= req_div;
              kick_q <= req_kick;
            end
          end else if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (div_q > W'(DIV_STEP)) begin
            div_q  <= div_q - W'(DIV_STEP);
            hold_q <= HCW'(HOLD_CYCLES);
          end else begin
            state_q <= S_OFF;
            level_q <= '0;
            div_q   <= '0;
          end
        end
        default: begin
          state_q <= S_OFF;
          level_q <= '0;
          div_q   <= '0;
          cnt_q   <= '0;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign delta_f     = kick_q;
  assign delta_n     = div_q;
  assign state       = state_q;
  assign level       = level_q;
  assign busy        = (state_q != S_OFF);
  assign event_count = ev_q;

endmodule
